// File: rtl/load_store_master_pkg.sv
// Shared types for the load/store bus master: access width, FSM encodings,
// buffered store entry and the alignment rule.
package load_store_master_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } width_e;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_WAIT  = 2'd1;
  localparam logic [1:0] STORE_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    width_e      width;
  } store_entry_t;

  function automatic logic is_misaligned(width_e width, logic [1:0] offset);
    case (width)
      HALF_WORD: return offset[0];
      WORD:      return offset != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_master_store_buffer.sv
// Posted-store FIFO with a per-entry word-address comparator so loads can
// detect a read-after-write hazard against any buffered store.
module store_buffer
  import load_store_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  store_entry_t       push_entry_i,
  input  logic               pop_i,
  output store_entry_t       head_o,
  output logic               full_o,
  output logic               empty_o,
  input  logic [29:0]        match_addr_i,
  output logic [DEPTH-1:0]   match_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  store_entry_t          entries_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;

  assign head_o  = entries_q[rd_ptr_q];
  assign full_o  = count_q == FULL_COUNT;
  assign empty_o = count_q == '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q          <= wr_ptr_q + AW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        // With a full FIFO wr_ptr == rd_ptr, but push is blocked when full,
        // so the set above and this clear never target the same slot.
        valid_q[rd_ptr_q] <= 1'b0;
      end
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Payload storage needs no reset: valid_q gates every use of it.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_q[i] && (entries_q[i].address[31:2] == match_addr_i);
    end
  end

endmodule

// File: rtl/load_store_master.sv
// Data-side bus master: issues loads directly, posts stores into a FIFO that
// drains in the background, one outstanding bus transaction at a time.
//
// state      | meaning
// IDLE       | no bus transaction outstanding
// LOAD_WAIT  | load request issued, waiting for load_valid
// STORE_WAIT | store request issued, waiting for store_done
module load_store_master
  import load_store_master_pkg::*;
#(
  parameter int STORE_BUFFER_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  output logic        load_request,
  output logic [31:0] load_address,
  input  logic        load_valid,
  input  logic [31:0] load_data,

  output logic        store_request,
  output logic [31:0] store_address,
  output logic [1:0]  store_width,
  output logic [31:0] store_data,
  input  logic        store_done,

  input  logic        load_i,
  input  logic [31:0] load_address_i,
  input  logic [1:0]  load_width_i,
  input  logic        load_signed_i,
  output logic        load_ready_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,

  input  logic        store_i,
  input  logic [31:0] store_address_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  store_width_i,
  output logic        store_ready_o,

  output logic        misaligned_o,
  output logic        buffer_empty_o
);

  logic [1:0]   state_q, state_d;
  logic         load_request_q;
  logic [31:0]  load_address_q;
  width_e       load_width_q;
  logic         load_signed_q;
  logic         store_request_q;
  logic [31:0]  store_address_q;
  logic [31:0]  store_data_q;
  width_e       store_width_q;
  logic         misaligned_q;

  store_entry_t                  push_entry;
  store_entry_t                  head_entry;
  logic                          fifo_full, fifo_empty;
  logic [STORE_BUFFER_DEPTH-1:0] fifo_match;

  logic idle_eff, inflight_hit, hazard;
  logic load_accept, load_mis, load_issue;
  logic store_accept, store_mis, push, pop;

  function automatic logic [31:0] extract_load(logic [31:0] word, logic [1:0] offset,
                                               width_e width, logic sign_ext);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (width)
      BYTE:      return {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      HALF_WORD: return {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   return shifted;
    endcase
  endfunction

  assign push_entry = '{address: store_address_i, data: store_data_i,
                        width: width_e'(store_width_i)};

  store_buffer #(.DEPTH(STORE_BUFFER_DEPTH)) u_store_buffer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head_entry),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .match_addr_i (load_address_i[31:2]),
    .match_o      (fifo_match)
  );

  // The response cycle counts as idle so back-to-back transactions run at
  // one per two cycles instead of three.
  assign idle_eff = (state_q == IDLE)
                 || (state_q == LOAD_WAIT  && load_valid)
                 || (state_q == STORE_WAIT && store_done);

  assign inflight_hit = (state_q == STORE_WAIT)
                     && (store_address_q[31:2] == load_address_i[31:2]);
  assign hazard       = (|fifo_match) || inflight_hit;

  assign load_ready_o = idle_eff && !hazard;
  assign load_accept  = load_i && load_ready_o;
  assign load_mis     = is_misaligned(width_e'(load_width_i), load_address_i[1:0]);
  assign load_issue   = load_accept && !load_mis;

  assign store_ready_o = !fifo_full;
  assign store_accept  = store_i && store_ready_o;
  assign store_mis     = is_misaligned(width_e'(store_width_i), store_address_i[1:0]);
  assign push          = store_accept && !store_mis;
  assign pop           = idle_eff && !load_issue && !fifo_empty;

  always_comb begin
    state_d = state_q;
    if (load_issue) begin
      state_d = LOAD_WAIT;
    end else if (pop) begin
      state_d = STORE_WAIT;
    end else if (idle_eff) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      load_request_q  <= 1'b0;
      load_address_q  <= '0;
      load_width_q    <= BYTE;
      load_signed_q   <= 1'b0;
      store_request_q <= 1'b0;
      store_address_q <= '0;
      store_data_q    <= '0;
      store_width_q   <= BYTE;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_request_q  <= load_issue;
      store_request_q <= pop;
      misaligned_q    <= (load_accept && load_mis) || (store_accept && store_mis);
      if (load_issue) begin
        load_address_q <= load_address_i;
        load_width_q   <= width_e'(load_width_i);
        load_signed_q  <= load_signed_i;
      end
      if (pop) begin
        store_address_q <= head_entry.address;
        store_data_q    <= head_entry.data;
        store_width_q   <= head_entry.width;
      end
    end
  end

  assign load_request  = load_request_q;
  assign load_address  = load_address_q;
  assign store_request = store_request_q;
  assign store_address = store_address_q;
  assign store_width   = store_width_q;
  assign store_data    = store_data_q;

  assign load_valid_o = (state_q == LOAD_WAIT) && load_valid;
  assign load_data_o  = load_valid_o
                      ? extract_load(load_data, load_address_q[1:0], load_width_q, load_signed_q)
                      : '0;

  assign misaligned_o   = misaligned_q;
  assign buffer_empty_o = fifo_empty && (state_q != STORE_WAIT);

endmodule

// File: tb/tb_load_store_master.sv
// Directed bench for load_store_master: a small memory responder, a scoreboard
// of expected load results and store transactions, and timing/boundary checks.
module tb_load_store_master;
  import load_store_master_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        load_request, load_valid, store_request, store_done;
  logic [31:0] load_address, load_data, store_address, store_data;
  logic [1:0]  store_width;
  logic        load_i, load_signed_i, load_ready_o, load_valid_o;
  logic [31:0] load_address_i, load_data_o;
  logic [1:0]  load_width_i, store_width_i;
  logic        store_i, store_ready_o, misaligned_o, buffer_empty_o;
  logic [31:0] store_address_i, store_data_i;

  always #5 clk_i = ~clk_i;

  load_store_master #(.STORE_BUFFER_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .load_request(load_request), .load_address(load_address),
    .load_valid(load_valid), .load_data(load_data),
    .store_request(store_request), .store_address(store_address),
    .store_width(store_width), .store_data(store_data), .store_done(store_done),
    .load_i(load_i), .load_address_i(load_address_i), .load_width_i(load_width_i),
    .load_signed_i(load_signed_i), .load_ready_o(load_ready_o),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .store_i(store_i), .store_address_i(store_address_i), .store_data_i(store_data_i),
    .store_width_i(store_width_i), .store_ready_o(store_ready_o),
    .misaligned_o(misaligned_o), .buffer_empty_o(buffer_empty_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
  } st_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          store_delay = 0;
  logic [31:0] mem [0:63];
  logic [31:0] exp_load_q [$];
  st_t         exp_store_q [$];
  int          req_cycles [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Load responder: one valid cycle after every request-high cycle.
  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    forever begin
      @(negedge clk_i);
      if (load_request) begin
        @(posedge clk_i); #1;
        load_valid = 1'b1;
        load_data  = mem[load_address[7:2]];
        @(posedge clk_i); #1;
        load_valid = 1'b0;
        load_data  = '0;
      end
    end
  end

  // Store responder: lane write, then done after store_delay extra cycles.
  initial begin
    int d, idx, off;
    store_done = 1'b0;
    forever begin
      @(negedge clk_i);
      if (store_request) begin
        d   = store_delay;
        idx = int'(store_address[7:2]);
        off = int'(store_address[1:0]);
        case (store_width)
          2'd0:    mem[idx][8*off +: 8]         = store_data[7:0];
          2'd1:    mem[idx][16*(off/2) +: 16]   = store_data[15:0];
          default: mem[idx]                     = store_data;
        endcase
        @(posedge clk_i);
        repeat (d) @(posedge clk_i);
        #1 store_done = 1'b1;
        @(posedge clk_i);
        #1 store_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [31:0] e;
    st_t         s;
    forever begin
      @(negedge clk_i);
      if (load_valid_o) begin
        if (exp_load_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load_valid: got data 0x%08h expected no response", load_data_o);
        end else begin
          e = exp_load_q.pop_front();
          check("load_data", load_data_o, e);
        end
      end
      if (store_request) begin
        req_cycles.push_back(cyc);
        if (exp_store_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_store_request: got addr 0x%08h expected none", store_address);
        end else begin
          s = exp_store_q.pop_front();
          check("store_address", store_address, s.a);
          check("store_data", store_data, s.d);
          check("store_width", {30'd0, store_width}, {30'd0, s.w});
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [1:0] w, input logic sgn,
                         input logic [31:0] exp, input bit expect_resp,
                         output int waits, output int acc_cyc);
    bit acc = 0;
    waits = 0;
    @(negedge clk_i);
    load_i = 1'b1; load_address_i = a; load_width_i = w; load_signed_i = sgn;
    while (!acc) begin
      #2 acc = load_ready_o;
      @(posedge clk_i);
      if (acc) begin
        if (expect_resp) exp_load_q.push_back(exp);
      end else begin
        waits++;
        if (waits > 100) begin
          checks++; errors++;
          $display("FAIL load_accept_timeout: addr 0x%08h not accepted", a);
          break;
        end
      end
    end
    #1;
    acc_cyc = cyc;
    load_i = 1'b0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] w, input bit expect_issue);
    bit acc = 0;
    int waits = 0;
    @(negedge clk_i);
    store_i = 1'b1; store_address_i = a; store_data_i = d; store_width_i = w;
    while (!acc) begin
      #2 acc = store_ready_o;
      @(posedge clk_i);
      if (acc) begin
        if (expect_issue) exp_store_q.push_back('{a: a, d: d, w: w});
      end else begin
        waits++;
        if (waits > 100) begin
          checks++; errors++;
          $display("FAIL store_accept_timeout: addr 0x%08h not accepted", a);
          break;
        end
      end
    end
    #1 store_i = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int wt, t1, t2, n;
    rst_n_i = 1'b0;
    load_i = 1'b0; load_address_i = '0; load_width_i = '0; load_signed_i = 1'b0;
    store_i = 1'b0; store_address_i = '0; store_data_i = '0; store_width_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;

    repeat (2) @(negedge clk_i);
    check("reset_requests", {30'd0, load_request, store_request}, 32'd0);
    check("reset_load_address", load_address, 32'd0);
    check("reset_store_address", store_address, 32'd0);
    check("reset_store_data", store_data, 32'd0);
    check("reset_store_width", {30'd0, store_width}, 32'd0);
    check("reset_load_out", {31'd0, load_valid_o} | load_data_o, 32'd0);
    check("reset_misaligned", {31'd0, misaligned_o}, 32'd0);
    check("reset_ready_empty", {29'd0, load_ready_o, store_ready_o, buffer_empty_o}, 32'd7);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Basic word load and its timing.
    do_load(32'h10, WORD, 1'b0, 32'hDEADBEEF, 1, wt, t1);
    check("load_first_wait", wt, 0);
    @(negedge clk_i);
    check("load_req_cycle1", {30'd0, load_request, load_valid_o}, 32'd2);
    @(negedge clk_i);
    check("load_req_cycle2", {30'd0, load_request, load_valid_o}, 32'd1);

    // Back-to-back loads: sub-word extraction and two-cycle throughput.
    do_load(32'h13, BYTE, 1'b1, 32'hFFFFFFDE, 1, wt, t1);
    do_load(32'h12, HALF_WORD, 1'b0, 32'h0000DEAD, 1, wt, t2);
    check("load_spacing", t2 - t1, 2);
    do_load(32'h11, BYTE, 1'b0, 32'h000000BE, 1, wt, t1);
    do_load(32'h10, HALF_WORD, 1'b1, 32'hFFFFBEEF, 1, wt, t1);
    do_load(32'h10, BYTE, 1'b1, 32'hFFFFFFEF, 1, wt, t1);
    do_load(32'h12, HALF_WORD, 1'b1, 32'hFFFFDEAD, 1, wt, t1);
    repeat (3) @(negedge clk_i);

    // Misaligned load and store are dropped with a one-cycle pulse.
    do_load(32'h05, HALF_WORD, 1'b0, 32'h0, 0, wt, t1);
    @(negedge clk_i);
    check("mis_load_pulse", {30'd0, misaligned_o, load_request}, 32'd2);
    @(negedge clk_i);
    check("mis_load_after", {30'd0, misaligned_o, load_ready_o}, 32'd1);
    push_store(32'h22, 32'h55AA55AA, WORD, 0);
    @(negedge clk_i);
    check("mis_store_pulse", {30'd0, misaligned_o, buffer_empty_o}, 32'd3);
    @(negedge clk_i);
    check("mis_store_after", {31'd0, misaligned_o}, 32'd0);

    // Fill the FIFO behind a slow store, then drain at full rate.
    store_delay = 6;
    req_cycles.delete();
    push_store(32'h40, 32'h11110000, WORD, 1);
    push_store(32'h44, 32'h22220000, WORD, 1);
    push_store(32'h49, 32'h000000AB, BYTE, 1);
    push_store(32'h4A, 32'h0000BEEF, HALF_WORD, 1);
    push_store(32'h50, 32'h55550000, WORD, 1);
    @(negedge clk_i);
    check("fifo_full", {30'd0, store_ready_o, buffer_empty_o}, 32'd0);
    store_delay = 0;
    n = 0;
    while (!buffer_empty_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_empty", {31'd0, buffer_empty_o}, 32'd1);
    check("drain_ready", {31'd0, store_ready_o}, 32'd1);
    check("drain_count", req_cycles.size(), 5);
    if (req_cycles.size() == 5) begin
      for (int i = 2; i < 5; i++) check("drain_spacing", req_cycles[i] - req_cycles[i-1], 2);
    end
    do_load(32'h48, WORD, 1'b0, 32'hBEEFAB00, 1, wt, t1);
    do_load(32'h40, WORD, 1'b0, 32'h11110000, 1, wt, t1);
    repeat (3) @(negedge clk_i);

    // Load hitting a buffered store waits for the store to complete.
    push_store(32'h20, 32'h12345678, WORD, 1);
    do_load(32'h22, HALF_WORD, 1'b0, 32'h00001234, 1, wt, t1);
    check("hazard_stalled", {31'd0, wt >= 2}, 32'd1);
    repeat (4) @(negedge clk_i);

    // Reset while a load is outstanding; the late valid must be ignored.
    do_load(32'h10, WORD, 1'b0, 32'h0, 0, wt, t1);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_mid_request", {31'd0, load_request}, 32'd0);
    check("rst_mid_address", load_address, 32'd0);
    check("rst_mid_ready", {29'd0, load_ready_o, store_ready_o, buffer_empty_o}, 32'd7);
    @(negedge clk_i);
    check("rst_late_valid_seen", {31'd0, load_valid}, 32'd1);
    check("rst_late_valid_out", {31'd0, load_valid_o}, 32'd0);
    #1 rst_n_i = 1'b1;
    #1 check("rst_late_valid_after", {31'd0, load_valid_o} | load_data_o, 32'd0);
    repeat (3) @(negedge clk_i);

    do_load(32'h20, WORD, 1'b0, 32'h12345678, 1, wt, t1);
    repeat (4) @(negedge clk_i);
    check("load_queue_drained", exp_load_q.size(), 0);
    check("store_queue_drained", exp_store_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
